// File: rtl/accelerator_scalar_logarithm_function.sv
// Iterative fixed-point logarithm: normalize to m*2^k, extract log2 fraction bits by repeated squaring, then scale by ln2.
// Define ACCELERATOR_LOGARITHM_BASE2_EN to output log2 directly and drop the ln2 multiplier.
module accelerator_scalar_logarithm_function #(
    parameter int DATA_SIZE    = 64,
    parameter int FRAC_SIZE    = 32,
    parameter int CONTROL_SIZE = 6,
    parameter logic [DATA_SIZE-1:0] LN2_CONSTANT = 64'h00000000B17217F7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int MANT_W = FRAC_SIZE + 1;
    localparam int Y2_W   = FRAC_SIZE + 2;

    typedef enum logic [1:0] {IDLE, NORMALIZE, ITERATE, SCALE} state_t;

    state_t                       state;
    logic [DATA_SIZE-1:0]         operand;
    logic [MANT_W-1:0]            mantissa;
    logic signed [DATA_SIZE-1:0]  log2_acc;
    logic                         zero_flag;
    logic [CONTROL_SIZE-1:0]      counter;

    int                           msb_pos;
    logic [DATA_SIZE-1:0]         aligned;
    logic [MANT_W-1:0]            mantissa_init;
    logic signed [DATA_SIZE-1:0]  log2_init;
    logic [2*MANT_W-1:0]          y_square;
    logic [Y2_W-1:0]              y2;
    logic [CONTROL_SIZE-1:0]      bit_index;
    logic signed [DATA_SIZE-1:0]  scale_result;

    always_comb begin
        msb_pos = 0;
        for (int i = 0; i < DATA_SIZE; i++) begin
            if (operand[i]) begin
                msb_pos = i;
            end
        end
    end

    // Move the leading one to bit FRAC_SIZE so the mantissa lies in [1,2)
    always_comb begin
        if (msb_pos >= FRAC_SIZE) begin
            aligned = operand >> (msb_pos - FRAC_SIZE);
        end else begin
            aligned = operand << (FRAC_SIZE - msb_pos);
        end
    end

    assign mantissa_init = MANT_W'(aligned);
    assign log2_init     = DATA_SIZE'(msb_pos - FRAC_SIZE) <<< FRAC_SIZE;
    assign y_square      = mantissa * mantissa;
    assign y2            = Y2_W'(y_square >> FRAC_SIZE);
    assign bit_index     = CONTROL_SIZE'(FRAC_SIZE - 1) - counter;

`ifdef ACCELERATOR_LOGARITHM_BASE2_EN
    assign scale_result = log2_acc;
`else
    localparam logic signed [DATA_SIZE-1:0] LN2_SIGNED = LN2_CONSTANT;
    logic signed [2*DATA_SIZE-1:0] product;

    assign product      = log2_acc * LN2_SIGNED;
    assign scale_result = DATA_SIZE'(product >>> FRAC_SIZE);
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            operand   <= '0;
            mantissa  <= '0;
            log2_acc  <= '0;
            zero_flag <= 1'b0;
            counter   <= '0;
            READY     <= 1'b0;
            DATA_OUT  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    READY <= 1'b0;
                    if (START) begin
                        operand <= DATA_IN;
                        state   <= NORMALIZE;
                    end
                end
                NORMALIZE: begin
                    zero_flag <= (operand == '0);
                    mantissa  <= mantissa_init;
                    log2_acc  <= log2_init;
                    counter   <= '0;
                    state     <= ITERATE;
                end
                // Squared mantissa >= 2 yields a 1 bit and is halved back into [1,2)
                ITERATE: begin
                    log2_acc[bit_index] <= y2[Y2_W-1];
                    if (y2[Y2_W-1]) begin
                        mantissa <= y2[Y2_W-1:1];
                    end else begin
                        mantissa <= y2[MANT_W-1:0];
                    end
                    counter <= counter + 1'b1;
                    if (counter == CONTROL_SIZE'(FRAC_SIZE - 1)) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    DATA_OUT <= zero_flag ? {1'b1, {(DATA_SIZE-1){1'b0}}} : scale_result;
                    READY    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
